// File: rtl/mem_pkg.sv
// Shared types and helpers for the Modified Enigma Machine streaming front end.
// Optional feature macro used by the sequencer: MEM_SEQ_ALPHA_ONLY_EN.
package mem_pkg;

  typedef logic [1:0] setting_t;
  typedef logic [7:0] char_t;

  localparam char_t ASCII_A = 8'h41;
  localparam char_t ASCII_Z = 8'h5A;

  // Payload held in the first pipeline stage (the one that feeds the MEM core).
  typedef struct packed {
    char_t    ch;
    setting_t setting;
    logic     bypass;
  } s1_data_t;

  // Payload held in the output stage.
  typedef struct packed {
    char_t    ch;
    setting_t setting;
  } s2_data_t;

  // One rotor step: 2-bit modular increment or decrement.
  function automatic setting_t step_setting(setting_t s, bit up);
    return up ? setting_t'(s + 2'd1) : setting_t'(s - 2'd1);
  endfunction

  // True for upper-case letters 'A'..'Z'.
  function automatic logic is_alpha(char_t c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/mem_skid_stage.sv
// One-entry valid/ready register stage. Accepts when empty or when the
// downstream takes the current entry in the same cycle.
module mem_skid_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  // Load on handshake, drain on downstream accept, hold otherwise.
  always_ff @(posedge clk) begin
    // NOTE: the payload is reset as well, since it is visible on the block's
    // outputs and must read zero after reset; state uses non-blocking assigns.
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_char_sequencer.sv
// Streaming front end for the MEM core: accepts plaintext characters, assigns
// each its rotor setting, presents it to the external combinational core and
// returns the core's result as a registered valid/ready stream.
// Optional feature: define MEM_SEQ_ALPHA_ONLY_EN to pass non-letters through
// unencrypted without stepping the setting or counting them.
module mem_char_sequencer
  import mem_pkg::*;
#(
  parameter setting_t START_SETTING = 2'b10,
  parameter bit       STEP_UP       = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_char,
  input  logic        s_sof,
  input  logic        key_load,
  input  logic [1:0]  key_setting,
  output logic [7:0]  mem_in,
  output logic [1:0]  mem_setting,
  input  logic [7:0]  mem_out,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_char,
  output logic [1:0]  m_setting,
  output logic [15:0] char_count
);

  setting_t key_reg;
  setting_t cur_setting;
  logic [15:0] count_q;

  logic     s1_in_valid;
  logic     s1_in_ready;
  logic     s1_valid;
  logic     s2_in_ready;
  logic     accept;
  logic     bypass;
  setting_t used_setting;
  s1_data_t s1_in;
  s1_data_t s1_q;
  s2_data_t s2_in;
  s2_data_t s2_q;

  // A key load blocks acceptance so the two never coincide.
  assign s1_in_valid  = s_valid && !key_load;
  assign s_ready      = !key_load && s1_in_ready;
  assign accept       = s_valid && s_ready;
  assign used_setting = s_sof ? key_reg : cur_setting;

`ifdef MEM_SEQ_ALPHA_ONLY_EN
  assign bypass = !is_alpha(s_char);
`else
  assign bypass = 1'b0;
`endif

  assign s1_in = '{ch: s_char, setting: used_setting, bypass: bypass};

  // Output stage takes the core's result, or the raw character when bypassed.
  assign s2_in = '{ch: (s1_q.bypass ? s1_q.ch : mem_out), setting: s1_q.setting};

  mem_skid_stage #(.W($bits(s1_data_t))) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  mem_skid_stage #(.W($bits(s2_data_t))) u_s2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (s2_q)
  );

  assign mem_in      = s1_q.ch;
  assign mem_setting = s1_q.setting;
  assign m_char      = s2_q.ch;
  assign m_setting   = s2_q.setting;
  assign char_count  = count_q;

  // Key register, running rotor setting and per-message character counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg     <= START_SETTING;
      cur_setting <= START_SETTING;
      count_q     <= 16'd0;
    end else if (key_load) begin
      key_reg     <= key_setting;
      cur_setting <= key_setting;
    end else if (accept) begin
      if (!bypass) begin
        cur_setting <= step_setting(used_setting, STEP_UP);
        count_q     <= s_sof ? 16'd1 : count_q + 16'd1;
      end else if (s_sof) begin
        cur_setting <= key_reg;
        count_q     <= 16'd0;
      end
    end
  end

endmodule

// File: doc/mem_char_sequencer.md
# mem_char_sequencer

Streaming front end for the Modified Enigma Machine core. Accepts plaintext ASCII characters over a valid/ready handshake and presents each one to the combinational MEM core together with that character's rotor setting. It steps the setting once per encrypted character and returns the core's output as a registered valid/ready stream. It sits between the message source and the MEM core, and also consumes the core's output.

## Interface
- START_SETTING, 2'b10: rotor setting after reset, and the default key.
- STEP_UP, 0: 0 steps the setting down (10→01→00→11→10…); 1 steps it up.
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- s_valid  in  1  input character valid.
- s_ready  out  1  input character accepted when high together with s_valid.
- s_char  in  8  ASCII plaintext.
- s_sof  in  1  start of message; qualified by the s_valid && s_ready handshake.
- key_load  in  1  loads key_setting.
- key_setting  in  2  new key.
- mem_in  out  8  character driven to the MEM core.
- mem_setting  out  2  setting driven to the MEM core.
- mem_out  in  8  combinational result from the MEM core.
- m_valid  out  1  output character valid.
- m_ready  in  1  downstream accepts the output character.
- m_char  out  8  ciphertext.
- m_setting  out  2  setting used for m_char.
- char_count  out  16  number of stepped characters since the last s_sof.

## Operation
- Pipeline has two stages:
  - S1 register: v1, char, setting, bypass flag. It drives mem_in and mem_setting.
  - S2 register: v2, m_char, m_setting. It captures mem_out, or the S1 char when bypass is set.
- Internal registers: key_reg and cur_setting.
- s_ready = !key_load && (!v1 || !v2 || m_ready).
- S1→S2 transfer when v1 && (!v2 || m_ready).
- S2 clears on m_ready unless it is refilled in the same cycle.
- On accept:
  - The character's setting is key_reg if s_sof, else cur_setting.
  - cur_setting becomes step(setting used).
  - char_count becomes 1 if s_sof, else char_count+1. It wraps 0xFFFF→0x0000.
- step(): 2-bit modular ±1 selected by STEP_UP. 2'b00 steps down to 2'b11, and 2'b11 steps up to 2'b00.
- key_load: key_reg and cur_setting take key_setting. s_ready is forced low in that cycle, so a load and an accept never coincide. Characters already in the pipeline keep their settings.
- Reset values:
  - v1=v2=0, so m_valid=0.
  - m_char=0x00, m_setting=2'b00, mem_in=0x00, mem_setting=2'b00.
  - key_reg=cur_setting=START_SETTING, char_count=0.
- Reset mid-operation: both stages are flushed and their contents are never output. Reset overrides key_load and any accept.

## Timing
- Latency: a character accepted at edge N shows on mem_in/mem_setting after edge N, and m_valid is high after edge N+1, i.e. 2 cycles.
- Throughput: 1 character per cycle while m_ready=1.
- Backpressure: with m_ready low, up to 2 characters are held. s_ready falls once both stages are valid.
- m_char and m_setting hold stable while m_valid && !m_ready.
- mem_out is sampled only on the edge where S1 transfers to S2.

## Configuration
- MEM_SEQ_ALPHA_ONLY_EN defined:
  - Characters outside 0x41–0x5A ('A'–'Z') set the bypass flag.
  - A bypassed character passes through unchanged, and m_setting shows the setting that would have been used.
  - A bypassed character does not step cur_setting and does not increment char_count.
  - An s_sof on a bypassed character still resets char_count to 0 and cur_setting to key_reg.
- Undefined: every character goes through MEM, steps the setting and counts.

## Structure
- Shared package mem_pkg:
  - setting_t (2-bit)
  - char_t (8-bit)
  - constants ASCII_A=8'h41 and ASCII_Z=8'h5A
  - function step_setting(setting_t, bit up)
- Natural sub-module: mem_skid_stage, a one-entry valid/ready register, instantiated for S1 and S2.
- The MEM core is instantiated alongside this block, not inside it.

## Test plan
The bench stub MEM computes mem_out = mem_in + mem_setting.
- Basic stream: reset, START_SETTING=2'b10, stream "HELLOWORLD" back-to-back with m_ready=1 → first m_valid 2 cycles after the first accept, then one character per cycle. m_setting runs 10,01,00,11,10,01,00,11,10,01 and the first m_char is 0x4A. Final char_count=10.
- Backpressure: m_ready low for 4 cycles after the first output → s_ready is low once 2 characters are held. Output order and values are unchanged, with no duplicates or drops.
- Key load: key_load with key_setting=2'b11 while idle, then "AB" with s_sof on 'A' → settings 11,10 and m_char 0x44,0x44. Asserting key_load together with s_valid → s_ready=0 that cycle.
- Start of message mid-stream: s_sof on the 4th character of "ABCDE" → that character uses key_reg (10) and char_count becomes 1. 'E' uses 01.
- Reset mid-operation: reset with both stages full and m_ready=0 → next cycle m_valid=0 and cur_setting=2'b10. The flushed characters never appear.
- Alpha-only: "A B" → with MEM_SEQ_ALPHA_ONLY_EN, outputs are 0x43 (10), 0x20 (setting 01, bypassed), 0x43 (01), and char_count=2. Without the macro, outputs are 0x43, 0x21, 0x42, and char_count=3.
